// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// Issues one req/ack data-memory access per instruction and stalls EX/MEM until done.
module mem_access_unit #(
    parameter int addrWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst,
    input  logic [31:0]          alu_out,
    input  logic [31:0]          rs2_rdata,
    input  logic                 dmem_ack,
    input  logic [31:0]          dmem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [addrWidth-1:0] dmem_addr,
    output logic [31:0]          dmem_wdata,
    output logic [3:0]           dmem_wstrb,
    output logic                 stall,
    output logic [31:0]          ld_data,
    output logic                 ld_valid,
    output logic                 mem_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t state_q, state_d;

    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          ld_data_q, ld_data_d;
    logic                 ld_valid_q, ld_valid_d;
    logic                 mem_err_q, mem_err_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           a_q, a_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic        is_load;
    logic        is_store;
    logic        load_ok;
    logic        store_ok;
    logic        legal_op;
    logic        illegal_op;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;
    logic        stall_c;
    logic        unused_bits;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign a      = alu_out[1:0];

    // Only opcode, funct3 and the low address bits steer this stage.
    assign unused_bits = ^{inst[31:15], inst[11:7], alu_out};

    // Classify the held instruction and check width/alignment legality.
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        load_ok  = 1'b0;
        store_ok = 1'b0;
        case (f3)
            3'd0, 3'd4: load_ok = 1'b1;
            3'd1, 3'd5: load_ok = ~a[0];
            3'd2:       load_ok = (a == 2'b00);
            default:    load_ok = 1'b0;
        endcase
        case (f3)
            3'd0:    store_ok = 1'b1;
            3'd1:    store_ok = ~a[0];
            3'd2:    store_ok = (a == 2'b00);
            default: store_ok = 1'b0;
        endcase
        legal_op   = (is_load & load_ok) | (is_store & store_ok);
        illegal_op = (is_load | is_store) & ~legal_op;
    end

    // Replicate store data across lanes and pick the byte enables.
    always_comb begin
        st_wdata = rs2_rdata;
        st_wstrb = 4'b1111;
        case (f3[1:0])
            2'd0: begin
                st_wdata = {4{rs2_rdata[7:0]}};
                st_wstrb = 4'b0001 << a;
            end
            2'd1: begin
                st_wdata = {2{rs2_rdata[15:0]}};
                st_wstrb = 4'b0011 << a;
            end
            default: begin
                st_wdata = rs2_rdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Pull the addressed lane out of the read word and extend it.
    always_comb begin
        rd_shift = dmem_rdata >> {a_q, 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'd0:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    ld_ext = {24'd0, rd_byte};
            3'd1:    ld_ext = {{16{rd_half[15]}}, rd_half};
            3'd5:    ld_ext = {16'd0, rd_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // Access sequencing: detect in IDLE, wait for ack in REQ, release in DONE.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        mem_err_d  = 1'b0;
        f3_d       = f3_q;
        a_d        = a_q;
        stall_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (legal_op) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {alu_out[addrWidth-1:2], 2'b00};
                    wdata_d = is_store ? st_wdata : 32'd0;
                    wstrb_d = is_store ? st_wstrb : 4'd0;
                    f3_d    = f3;
                    a_d     = a;
                    state_d = REQ;
                end else if (illegal_op) begin
                    mem_err_d = 1'b1;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        ld_data_d  = ld_ext;
                        ld_valid_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // The old instruction is still visible here; never reissue it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            ld_data_q  <= 32'd0;
            ld_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
            f3_q       <= 3'd0;
            a_q        <= 2'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            mem_err_q  <= mem_err_d;
            f3_q       <= f3_d;
            a_q        <= a_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign stall      = stall_c;
    assign ld_data    = ld_data_q;
    assign ld_valid   = ld_valid_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the MEM-stage load/store engine.
// Expected requests and load results are queued at issue and popped at completion.
module tb_mem_access_unit;

    localparam int AW = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } req_t;

    logic          clk;
    logic          rst;
    logic [31:0]   inst;
    logic [31:0]   alu_out;
    logic [31:0]   rs2_rdata;
    logic          dmem_ack;
    logic [31:0]   dmem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_wstrb;
    logic          stall;
    logic [31:0]   ld_data;
    logic          ld_valid;
    logic          mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    req_t        exp_req_q[$];
    logic [31:0] exp_ld_q[$];
    logic        stall_log[$];

    int            o_stalls;
    int            o_reqs;
    int            o_lvcnt;
    logic [AW-1:0] o_addr;
    logic          o_we;
    logic [31:0]   o_wdata;
    logic [3:0]    o_wstrb;
    logic          o_lv;
    logic [31:0]   o_ld;
    logic          o_tmo;

    mem_access_unit #(.addrWidth(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .alu_out    (alu_out),
        .rs2_rdata  (rs2_rdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd1, op};
    endfunction

    // Drive one mem op starting in IDLE; memory acks after `waits` REQ cycles.
    task automatic run_op(input logic [31:0] i, input logic [31:0] a,
                          input logic [31:0] r2, input logic [31:0] rd,
                          input int waits);
        int   nreq;
        logic seen;
        logic done;
        logic prev_req;
        inst = i; alu_out = a; rs2_rdata = r2; dmem_rdata = rd; dmem_ack = 1'b0;
        o_stalls = 0; o_reqs = 0; o_lvcnt = 0; o_lv = 1'b0; o_ld = 32'd0;
        o_addr = '0; o_we = 1'b0; o_wdata = 32'd0; o_wstrb = 4'd0;
        o_tmo = 1'b1; nreq = 0; seen = 1'b0; done = 1'b0; prev_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) o_stalls++;
            stall_log.push_back(stall);
            if (ld_valid) o_lvcnt++;
            if (dmem_req && !prev_req) begin
                o_reqs++;
                o_addr = dmem_addr; o_we = dmem_we;
                o_wdata = dmem_wdata; o_wstrb = dmem_wstrb;
            end
            prev_req = dmem_req;
            if (seen && !dmem_req) begin
                o_lv = ld_valid; o_ld = ld_data; done = 1'b1;
            end
            dmem_ack = dmem_req && (nreq == waits);
            if (dmem_req) begin
                nreq++;
                seen = 1'b1;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (done) begin
                o_tmo = 1'b0;
                inst = NOP;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inst = NOP; alu_out = 32'd0; rs2_rdata = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== '0) begin
            n_bad++;
            $display("FAIL reset_port got %b/%b/%h/%h/%b exp all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
        end
        n_cmp++;
        if ({ld_data, ld_valid, mem_err, stall} !== '0) begin
            n_bad++;
            $display("FAIL reset_out got ld=%h lv=%b err=%b st=%b exp 0", ld_data, ld_valid, mem_err, stall);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL nop_idle got stall=%b req=%b exp 0 0", stall, dmem_req);
        end
    endtask

    task automatic test_lw();
        req_t r;
        logic [31:0] e;
        exp_req_q.push_back('{addr: 16'h0104, we: 1'b0, wdata: 32'd0, wstrb: 4'd0});
        exp_ld_q.push_back(32'hDEADBEEF);
        run_op(mk(7'b0000011, 3'd2), 32'h0000_0104, 32'd0, 32'hDEADBEEF, 2);
        r = exp_req_q.pop_front();
        e = exp_ld_q.pop_front();
        n_cmp++;
        if (o_tmo !== 1'b0) begin n_bad++; $display("FAIL lw_timeout got %b exp 0", o_tmo); end
        n_cmp++;
        if (o_addr !== r.addr || o_we !== r.we || o_wstrb !== r.wstrb) begin
            n_bad++;
            $display("FAIL lw_req got %h/%b/%b exp %h/%b/%b", o_addr, o_we, o_wstrb, r.addr, r.we, r.wstrb);
        end
        n_cmp++;
        if (o_stalls !== 4) begin n_bad++; $display("FAIL lw_stall_cycles got %0d exp 4", o_stalls); end
        n_cmp++;
        if (o_ld !== e || o_lv !== 1'b1) begin
            n_bad++;
            $display("FAIL lw_data got %h lv=%b exp %h lv=1", o_ld, o_lv, e);
        end
        @(negedge clk);
        n_cmp++;
        if (o_lvcnt !== 1 || ld_valid !== 1'b0 || ld_data !== e) begin
            n_bad++;
            $display("FAIL lw_pulse got cnt=%0d lv=%b ld=%h exp 1 0 %h", o_lvcnt, ld_valid, ld_data, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lb_lbu();
        logic [31:0] e;
        exp_ld_q.push_back(32'hFFFFFF80);
        exp_ld_q.push_back(32'h00000080);
        run_op(mk(7'b0000011, 3'd0), 32'h55AA_0203, 32'd0, 32'h80112233, 0);
        e = exp_ld_q.pop_front();
        n_cmp++;
        if (o_ld !== e || o_tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_data got %h tmo=%b exp %h", o_ld, o_tmo, e);
        end
        n_cmp++;
        if (o_addr !== 16'h0200 || o_stalls !== 2) begin
            n_bad++;
            $display("FAIL lb_addr got %h st=%0d exp 0200 2", o_addr, o_stalls);
        end
        run_op(mk(7'b0000011, 3'd4), 32'h0000_0203, 32'd0, 32'h80112233, 1);
        e = exp_ld_q.pop_front();
        n_cmp++;
        if (o_ld !== e || o_tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL lbu_data got %h tmo=%b exp %h", o_ld, o_tmo, e);
        end
        exp_ld_q.push_back(32'h00008765);
        run_op(mk(7'b0000011, 3'd5), 32'h0000_0300, 32'd0, 32'h12348765, 0);
        e = exp_ld_q.pop_front();
        n_cmp++;
        if (o_ld !== e) begin n_bad++; $display("FAIL lhu_data got %h exp %h", o_ld, e); end
    endtask

    task automatic test_store();
        req_t r;
        logic [31:0] keep;
        keep = ld_data;
        exp_req_q.push_back('{addr: 16'h0010, we: 1'b1, wdata: 32'hA5A5A5A5, wstrb: 4'b0100});
        exp_req_q.push_back('{addr: 16'h0020, we: 1'b1, wdata: 32'h12341234, wstrb: 4'b1100});
        run_op(mk(7'b0100011, 3'd0), 32'h0000_0012, 32'h000000A5, 32'd0, 1);
        r = exp_req_q.pop_front();
        n_cmp++;
        if (o_addr !== r.addr || o_we !== r.we || o_wdata !== r.wdata || o_wstrb !== r.wstrb) begin
            n_bad++;
            $display("FAIL sb_req got %h/%b/%h/%b exp %h/%b/%h/%b",
                     o_addr, o_we, o_wdata, o_wstrb, r.addr, r.we, r.wdata, r.wstrb);
        end
        n_cmp++;
        if (o_lvcnt !== 0 || o_ld !== keep) begin
            n_bad++;
            $display("FAIL sb_no_load got cnt=%0d ld=%h exp 0 %h", o_lvcnt, o_ld, keep);
        end
        run_op(mk(7'b0100011, 3'd1), 32'h0000_0022, 32'h00001234, 32'd0, 0);
        r = exp_req_q.pop_front();
        n_cmp++;
        if (o_addr !== r.addr || o_we !== r.we || o_wdata !== r.wdata || o_wstrb !== r.wstrb) begin
            n_bad++;
            $display("FAIL sh_req got %h/%b/%h/%b exp %h/%b/%h/%b",
                     o_addr, o_we, o_wdata, o_wstrb, r.addr, r.we, r.wdata, r.wstrb);
        end
    endtask

    task automatic test_err();
        logic [31:0] bad_inst[2];
        logic [31:0] bad_addr[2];
        bad_inst[0] = mk(7'b0000011, 3'd2); bad_addr[0] = 32'h0000_0006;
        bad_inst[1] = mk(7'b0100011, 3'd3); bad_addr[1] = 32'h0000_0008;
        for (int k = 0; k < 2; k++) begin
            inst = bad_inst[k]; alu_out = bad_addr[k];
            @(negedge clk);
            n_cmp++;
            if (stall !== 1'b0 || dmem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL err%0d_detect got stall=%b req=%b exp 0 0", k, stall, dmem_req);
            end
            @(posedge clk); #1;
            inst = NOP;
            @(negedge clk);
            n_cmp++;
            if (mem_err !== 1'b1 || dmem_req !== 1'b0 || ld_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL err%0d_pulse got err=%b req=%b lv=%b exp 1 0 0", k, mem_err, dmem_req, ld_valid);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if (mem_err !== 1'b0 || dmem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL err%0d_clear got err=%b req=%b exp 0 0", k, mem_err, dmem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int          req_total;
        logic [5:0]  pat;
        logic [31:0] e;
        req_t        r;
        stall_log.delete();
        exp_req_q.push_back('{addr: 16'h0040, we: 1'b1, wdata: 32'hCAFEF00D, wstrb: 4'b1111});
        exp_ld_q.push_back(32'hFFFF8001);
        run_op(mk(7'b0100011, 3'd2), 32'h0000_0040, 32'hCAFEF00D, 32'd0, 0);
        req_total = o_reqs;
        r = exp_req_q.pop_front();
        n_cmp++;
        if (o_wdata !== r.wdata || o_wstrb !== r.wstrb || o_addr !== r.addr) begin
            n_bad++;
            $display("FAIL sw_req got %h/%b/%h exp %h/%b/%h", o_wdata, o_wstrb, o_addr, r.wdata, r.wstrb, r.addr);
        end
        run_op(mk(7'b0000011, 3'd1), 32'h0000_0042, 32'd0, 32'h80017FFF, 0);
        req_total += o_reqs;
        e = exp_ld_q.pop_front();
        n_cmp++;
        if (o_ld !== e || o_we !== 1'b0) begin
            n_bad++;
            $display("FAIL lh_data got %h we=%b exp %h 0", o_ld, o_we, e);
        end
        pat = 6'd0;
        foreach (stall_log[j]) pat = {pat[4:0], stall_log[j]};
        n_cmp++;
        if (stall_log.size() !== 6 || pat !== 6'b110110) begin
            n_bad++;
            $display("FAIL b2b_stall got n=%0d %b exp 6 110110", stall_log.size(), pat);
        end
        n_cmp++;
        if (req_total !== 2) begin n_bad++; $display("FAIL b2b_reqs got %0d exp 2", req_total); end
    endtask

    task automatic test_rst_mid();
        logic hit;
        int   lv;
        hit = 1'b0; lv = 0;
        inst = mk(7'b0000011, 3'd2); alu_out = 32'h0000_0300;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (dmem_req) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (hit !== 1'b1) begin n_bad++; $display("FAIL rst_reach_req got %b exp 1", hit); end
        rst = 1'b1; inst = NOP;
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || ld_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_mid got req=%b st=%b ld=%h exp 0 0 0", dmem_req, stall, ld_data);
        end
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
        repeat (3) begin
            @(negedge clk);
            if (ld_valid || dmem_req) lv++;
        end
        dmem_ack = 1'b0;
        n_cmp++;
        if (lv !== 0 || ld_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_ack_ignored got hits=%0d ld=%h exp 0 0", lv, ld_data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_store();
        test_err();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine sitting on the consumer side of the EX/MEM stage register. It decodes the held instruction, drives a req/ack data-memory port with byte-lane strobes, and asserts `stall` back to the EX/MEM register until the access completes. It returns sign- or zero-extended load data to writeback.

## Interface
- `addrWidth`, default 16: data-memory byte-address width.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `inst` in 32: instruction held in the EX/MEM register.
- `alu_out` in 32: effective byte address.
- `rs2_rdata` in 32: store source data.
- `dmem_ack` in 1: memory completion, sampled only in state REQ.
- `dmem_rdata` in 32: read word, valid while `dmem_ack`=1.
- `dmem_req` out 1: access request, registered.
- `dmem_we` out 1: 1 = store, registered.
- `dmem_addr` out addrWidth: word-aligned address `{alu_out[addrWidth-1:2],2'b00}`, registered.
- `dmem_wdata` out 32: lane-replicated store data, registered.
- `dmem_wstrb` out 4: byte enables, registered; 0 for loads.
- `stall` out 1: hold EX/MEM register, combinational.
- `ld_data` out 32: extended load result, registered; held until the next load completes.
- `ld_valid` out 1: one-cycle pulse when `ld_data` is updated.
- `mem_err` out 1: one-cycle pulse on a misaligned access or illegal funct3.

## Operation
- Decode:
  - opcode `inst[6:0]`=0000011 is a load; 0100011 is a store; funct3 is `inst[14:12]`; `a` = `alu_out[1:0]`.
- Legal loads:
  - LB=0 and LBU=4 at any `a`.
  - LH=1 and LHU=5 require `a[0]`=0.
  - LW=2 requires `a`=0.
- Legal stores:
  - SB=0 at any `a`.
  - SH=1 requires `a[0]`=0.
  - SW=2 requires `a`=0.
- Any other funct3 or alignment on a mem opcode is an error.
- FSM states are IDLE, REQ and DONE.
- IDLE:
  - Legal mem op: `stall`=1; at the next edge load the `dmem_*` registers, set `dmem_req`=1, go to REQ.
  - Illegal mem op: `mem_err`=1 for 1 cycle, `stall`=0, no request, stay in IDLE.
  - Non-mem op: nothing happens.
- REQ:
  - `stall`=1; all `dmem_*` outputs stay stable.
  - On a sampled `dmem_ack`: clear `dmem_req`; for a load, capture the extended data into `ld_data`; go to DONE.
- DONE:
  - `stall`=0 so the EX/MEM register advances at this edge.
  - `ld_valid`=1 if the access was a load.
  - Always go to IDLE; the still-present old instruction is never reissued.
- Store data:
  - SB: `wdata`={4{rs2[7:0]}}, `wstrb`=0001<<a.
  - SH: `wdata`={2{rs2[15:0]}}, `wstrb`=0011<<a.
  - SW: `wdata`=rs2, `wstrb`=1111.
- Load extract:
  - Byte = `rdata[8a+7:8a]`; half = `rdata[16a[1]+15:16a[1]]`.
  - LB/LH sign-extend, LBU/LHU zero-extend.

## Timing
- Reset: state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `ld_data`, `ld_valid` and `mem_err` all 0. `stall`=0 unless IDLE decodes a legal mem op.
- Minimum latency is 3 cycles: detect (IDLE), REQ with `ack` in the first cycle, then DONE. Each extra wait cycle adds 1.
- `stall` is high for exactly (cycles in IDLE-detect + cycles in REQ).
- `dmem_req` stays high from entry into REQ until the edge that samples `ack`. `ack` outside REQ is ignored.
- Back-to-back mem ops: the next instruction arrives at the DONE edge and is detected in the following IDLE cycle. There is no bubble beyond DONE.
- `rst` mid-REQ: drops `dmem_req` immediately and returns to IDLE; `ld_data` is cleared.
- `mem_err` and `ld_valid` are never high in the same cycle.

## Test plan
- LW at `alu_out`=0x0104, ack after 2 wait cycles, `rdata`=0xDEADBEEF:
  - `dmem_addr`=0x0104, `wstrb`=0.
  - `stall` high 4 cycles.
  - `ld_data`=0xDEADBEEF with a 1-cycle `ld_valid`.
- LB / LBU at `a`=3 with `rdata`=0x80112233:
  - LB gives `ld_data`=0xFFFFFF80.
  - LBU gives 0x00000080.
- SB at `a`=2 with `rs2`=0x000000A5: `dmem_we`=1, `wstrb`=0100, `wdata`=0xA5A5A5A5. SH at `a`=2 with `rs2`=0x1234: `wstrb`=1100, `wdata`=0x12341234.
- LW at `a`=2, and funct3=3 store: `mem_err` 1-cycle pulse, `dmem_req` stays 0, `stall` 0.
- Back-to-back SW then LH, ack immediate:
  - Two separate requests.
  - `stall` pattern 1,1,0,1,1,0.
  - No duplicate request during DONE.
- `rst` asserted while in REQ (no ack):
  - `dmem_req`=0 and state IDLE immediately.
  - A later `ack` is ignored; `ld_valid` stays 0.
